// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial i0 - i1 - bin, LSB first, start/done handshake; ports clk, rst_n, start, i0, i1, bin -> busy, done, diff, borrow
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]       state;
  logic [WIDTH-1:0] a, b, res, res_n;
  logic [CW-1:0]    cnt;
  logic             br, d, br_n;
  always_comb begin
    d     = a[0] ^ b[0] ^ br;
    br_n  = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
    res_n = {d, res[WIDTH-1:1]};
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state == RUN) begin
      a   <= a >> 1;
      b   <= b >> 1;
      res <= res_n;
      br  <= br_n;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        diff   <= res_n;
        borrow <= br_n;
        state  <= DONE;
      end
    end else if (start) begin
      a     <= i0;
      b     <= i1;
      br    <= bin;
      cnt   <= '0;
      state <= RUN;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor against hand-computed results
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] i0 = '0, i1 = '0;
  logic       bin = 1'b0;
  logic       busy, done, borrow;
  logic [7:0] diff;
  int checks = 0, failures = 0;
  int n, dones, at;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i0(i0), .i1(i1), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] adder(input logic [7:0] x, input logic [7:0] y, input logic c);
    return x + y + {7'd0, c};
  endfunction

  task automatic run(input logic [7:0] x, input logic [7:0] y, input logic c,
                     input logic [7:0] ed, input logic eb);
    @(negedge clk);
    i0 = x; i1 = y; bin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; i0 = ~x; i1 = ~y; bin = ~c;
    chk("busy_after_start", {31'd0, busy}, 1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 8);
    chk("diff", {24'd0, diff}, {24'd0, ed});
    chk("borrow", {31'd0, borrow}, {31'd0, eb});
    chk("busy_on_done", {31'd0, busy}, 0);
    chk("adder_roundtrip", {24'd0, adder(diff, y, c)}, {24'd0, x});
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("diff_held", {24'd0, diff}, {24'd0, ed});
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_diff", {24'd0, diff}, 0);
    chk("rst_borrow", {31'd0, borrow}, 0);
    @(negedge clk) rst_n = 1'b1;

    run(8'h1D, 8'h05, 1'b0, 8'h18, 1'b0);
    run(8'h05, 8'h1D, 1'b0, 8'hE8, 1'b1);
    run(8'h4E, 8'hFF, 1'b0, 8'h4F, 1'b1);
    run(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run(8'hBF, 8'h02, 1'b1, 8'hBC, 1'b0);

    @(negedge clk);
    i0 = 8'h33; i1 = 8'h5C; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; at = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      i0 = 8'($urandom); i1 = 8'($urandom); start = (k == 3);
      @(posedge clk); #1;
      if (done) begin dones++; at = k; end
    end
    start = 1'b0;
    chk("ignore_start_dones", dones, 1);
    chk("ignore_start_edge", at, 8);
    chk("ignore_start_diff", {24'd0, diff}, 32'hD7);
    chk("ignore_start_borrow", {31'd0, borrow}, 1);

    @(negedge clk);
    i0 = 8'h11; i1 = 8'h22; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 0);
    chk("async_done", {31'd0, done}, 0);
    chk("async_diff", {24'd0, diff}, 0);
    chk("async_borrow", {31'd0, borrow}, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("no_done_after_reset", dones, 0);
    run(8'h2B, 8'h3B, 1'b0, 8'hF0, 1'b1);

    @(negedge clk);
    i0 = 8'hC8; i1 = 8'h5F; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) begin
      chk("b2b_busy", {31'd0, busy}, 1);
      chk("b2b_done_low", {31'd0, done}, 0);
      n = 0;
      while (!done && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_period", n, 8);
      chk("b2b_diff", {24'd0, diff}, 32'h69);
      chk("b2b_borrow", {31'd0, borrow}, 0);
      chk("b2b_busy_low", {31'd0, busy}, 0);
      @(posedge clk); #1;
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
